// File: rtl/uart_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_if
//   Bundles the requester-side and serializer-side handshakes of the UART TX
//   arbiter.
//
//   Handshake rule (both sides): a byte moves on a rising clk edge where valid
//   and ready are both high; a source keeps valid, data and last stable until
//   that edge; ready may depend combinationally on valid.
//
//   Signals:
//     req_valid   [NREQ]    per-requester byte valid
//     req_data    [8*NREQ]  requester i uses bits [8i+7:8i]
//     req_last    [NREQ]    final byte of a packet, qualified by req_valid
//     req_ready   [NREQ]    per-requester byte accepted
//     tx_valid / tx_data / tx_ready   byte stream to the serializer
//     grant       [NREQ]    one-hot owner, zero when unlocked
//     busy                  a packet is locked
//     abort_pulse           watchdog dropped a packet (one cycle)
//     dbg_state             arbiter FSM state (0 = IDLE, 1 = LOCKED)
//
//   Modports: slave = arbiter view, master = requesters + serializer view.
// ---------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
  parameter int NREQ = 3
);
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic              tx_valid;
  logic [7:0]        tx_data;
  logic              tx_ready;
  logic [NREQ-1:0]   grant;
  logic              busy;
  logic              abort_pulse;
  logic              dbg_state;

  modport slave (
    input  req_valid, req_data, req_last, tx_ready,
    output req_ready, tx_valid, tx_data, grant, busy, abort_pulse, dbg_state
  );

  modport master (
    output req_valid, req_data, req_last, tx_ready,
    input  req_ready, tx_valid, tx_data, grant, busy, abort_pulse, dbg_state
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//   Shares one byte-level UART transmitter between NREQ packet sources
//   (0 = status dump, 1 = RX echo, 2 = alarm notifier). Round-robin grant,
//   held for a whole packet so packets never interleave on the line.
//
//   Ports:
//     clk    system clock
//     rst_n  asynchronous active-low reset
//     bus    uart_tx_arbiter_if.slave (requester + serializer handshakes,
//            grant / busy / abort_pulse / dbg_state status)
//
//   Optional feature: define UART_TX_ARB_WATCHDOG_EN to add a stall watchdog
//   that drops a locked packet after TIMEOUT cycles with the owner's valid
//   low. Without it, abort_pulse is tied low and TIMEOUT is unused.
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int          NREQ    = 3,
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_tx_arbiter_if.slave bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] owner, owner_nxt;
  logic [IW-1:0] rr, rr_nxt;
  logic [IW-1:0] sel_idx;
  logic          own_valid;
  logic          own_last;
  logic          xfer;
  logic          abort_now;

  // (base + off) mod NREQ, for off in 0..NREQ-1.
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return IW'(s);
  endfunction

  // Round-robin pick: scanning downward and overwriting leaves the first
  // valid requester at or after rr (modulo NREQ).
  always_comb begin
    sel_idx = rr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.req_valid[wrap_add(rr, k)]) sel_idx = wrap_add(rr, k);
    end
  end

  // Owner data path is purely combinational: no per-byte latency.
  assign own_valid     = bus.req_valid[owner];
  assign own_last      = bus.req_last[owner];
  assign bus.tx_valid  = (state == LOCKED) && own_valid;
  assign bus.tx_data   = bus.tx_valid ? bus.req_data[8*owner +: 8] : 8'h00;
  assign xfer          = bus.tx_valid && bus.tx_ready;
  assign bus.req_ready = (state == LOCKED) ? (NREQ'(bus.tx_ready) << owner) : '0;
  assign bus.grant     = (state == LOCKED) ? (NREQ'(1) << owner) : '0;
  assign bus.busy      = (state == LOCKED);
  assign bus.dbg_state = state;

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    rr_nxt    = rr;
    case (state)
      IDLE: begin
        if (|bus.req_valid) begin
          state_nxt = LOCKED;
          owner_nxt = sel_idx;
        end
      end
      LOCKED: begin
        // Release on the last byte or on a watchdog abort; either way the
        // next search starts just past the released owner.
        if ((xfer && own_last) || abort_now) begin
          state_nxt = IDLE;
          rr_nxt    = wrap_add(owner, 1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= '0;
      rr    <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      rr    <= rr_nxt;
    end
  end

`ifdef UART_TX_ARB_WATCHDOG_EN
  logic [15:0] stall_cnt;
  logic        abort_q;

  // Only cycles with the owner's valid low count; serializer backpressure
  // (tx_ready low) never does. The counter is held at zero outside LOCKED,
  // so it starts from zero on every new lock.
  assign abort_now = (state == LOCKED) && !own_valid && (stall_cnt == TIMEOUT - 16'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      abort_q   <= 1'b0;
    end else begin
      abort_q <= abort_now;
      if ((state != LOCKED) || xfer) begin
        stall_cnt <= '0;
      end else if (!own_valid) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end

  assign bus.abort_pulse = abort_q;
`else
  assign abort_now       = 1'b0;
  assign bus.abort_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
//   Directed bench for uart_tx_arbiter (NREQ = 3, TIMEOUT = 16). Inputs are
//   driven 1 time unit after the rising edge, outputs are sampled on the
//   falling edge. Accepted bytes are checked against an expected queue of
//   {grant, data} entries.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;
  localparam int NREQ = 3;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  logic [NREQ+7:0] exp_q[$];
  logic [7:0]      ok_pkt[4];
  logic            rdy_pat[7];
  int              b;

  uart_tx_arbiter_if #(.NREQ(NREQ)) bus ();

  uart_tx_arbiter #(.NREQ(NREQ), .TIMEOUT(16'd16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [7:0] d, input logic l);
    bus.req_valid[i]       = v;
    bus.req_data[8*i +: 8] = d;
    bus.req_last[i]        = l;
  endtask

  task automatic clear_all();
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_byte", {21'b0, bus.grant, bus.tx_data}, 32'hFFFF_FFFF);
      end else begin
        chk("stream", {21'b0, bus.grant, bus.tx_data}, {21'b0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    total = 0;
    bad   = 0;
    ok_pkt  = '{8'h4F, 8'h4B, 8'h0D, 8'h0A};
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    rst_n = 1'b0;
    bus.tx_ready = 1'b0;
    clear_all();

    // Reset and idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx_valid", 32'(bus.tx_valid), 0);
    chk("rst_grant", 32'(bus.grant), 0);
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_grant", 32'(bus.grant), 0);
      chk("idle_busy", 32'(bus.busy), 0);
      chk("idle_tx_valid", 32'(bus.tx_valid), 0);
      chk("idle_abort", 32'(bus.abort_pulse), 0);
      cyc();
    end

    // Single packet "OK\r\n" from requester 1
    bus.tx_ready = 1'b1;
    set_req(1, 1'b1, ok_pkt[0], 1'b0);
    @(negedge clk);
    chk("sp_arb_tx_valid", 32'(bus.tx_valid), 0);
    chk("sp_arb_busy", 32'(bus.busy), 0);
    cyc();
    for (int i = 0; i < 4; i++) begin
      set_req(1, 1'b1, ok_pkt[i], (i == 3));
      exp_q.push_back({3'b010, ok_pkt[i]});
      @(negedge clk);
      chk("sp_tx_valid", 32'(bus.tx_valid), 1);
      chk("sp_tx_data", 32'(bus.tx_data), 32'(ok_pkt[i]));
      chk("sp_req_ready", 32'(bus.req_ready), 32'b010);
      cyc();
    end
    set_req(1, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    chk("sp_busy_after", 32'(bus.busy), 0);
    chk("sp_grant_after", 32'(bus.grant), 0);
    cyc();

    // Round-robin from reset: 0, 1, 2 with a one-cycle gap
    do_reset();
    for (int p = 0; p < 3; p++) set_req(p, 1'b1, {4'(10 + p), 4'h0}, 1'b0);
    @(negedge clk);
    chk("rr_first_idle", 32'(bus.busy), 0);
    cyc();
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 2; k++) begin
        set_req(p, 1'b1, {4'(10 + p), 4'(k)}, (k == 1));
        exp_q.push_back({3'(1 << p), 4'(10 + p), 4'(k)});
        @(negedge clk);
        chk("rr_grant", 32'(bus.grant), 32'(1 << p));
        chk("rr_req_ready", 32'(bus.req_ready), 32'(1 << p));
        cyc();
      end
      set_req(p, 1'b0, 8'h00, 1'b0);
      @(negedge clk);
      chk("rr_gap_busy", 32'(bus.busy), 0);
      chk("rr_gap_tx_valid", 32'(bus.tx_valid), 0);
      cyc();
    end

    // Backpressure on a 5-byte packet from requester 2
    bus.tx_ready = 1'b1;
    set_req(2, 1'b1, 8'hD0, 1'b0);
    @(negedge clk);
    chk("bp_arb_busy", 32'(bus.busy), 0);
    cyc();
    set_req(0, 1'b1, 8'h55, 1'b1);
    set_req(1, 1'b1, 8'h66, 1'b1);
    b = 0;
    for (int t = 0; t < 7; t++) begin
      bus.tx_ready = rdy_pat[t];
      set_req(2, 1'b1, 8'hD0 + 8'(b), (b == 4));
      if (rdy_pat[t]) exp_q.push_back({3'b100, 8'hD0 + 8'(b)});
      @(negedge clk);
      chk("bp_req_ready", 32'(bus.req_ready), rdy_pat[t] ? 32'b100 : 32'b000);
      chk("bp_tx_data", 32'(bus.tx_data), 32'(8'hD0 + 8'(b)));
      chk("bp_grant", 32'(bus.grant), 32'b100);
      if (rdy_pat[t]) b++;
      cyc();
    end
    clear_all();
    bus.tx_ready = 1'b1;
    @(negedge clk);
    chk("bp_busy_after", 32'(bus.busy), 0);
    cyc();

    // Reset in the middle of a 6-byte packet from requester 0
    set_req(0, 1'b1, 8'hE0, 1'b0);
    cyc();
    for (int i = 0; i < 2; i++) begin
      set_req(0, 1'b1, 8'hE0 + 8'(i), 1'b0);
      exp_q.push_back({3'b001, 8'hE0 + 8'(i)});
      @(negedge clk);
      chk("mr_grant", 32'(bus.grant), 32'b001);
      cyc();
    end
    set_req(0, 1'b1, 8'hE2, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mr_tx_valid", 32'(bus.tx_valid), 0);
    chk("mr_grant_rst", 32'(bus.grant), 0);
    chk("mr_req_ready", 32'(bus.req_ready), 0);
    cyc();
    set_req(0, 1'b1, 8'hF0, 1'b1);
    set_req(1, 1'b1, 8'hF1, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mr_idle_busy", 32'(bus.busy), 0);
    cyc();
    exp_q.push_back({3'b001, 8'hF0});
    @(negedge clk);
    chk("mr_first_grant", 32'(bus.grant), 32'b001);
    cyc();
    set_req(0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    chk("mr_gap_busy", 32'(bus.busy), 0);
    cyc();
    exp_q.push_back({3'b010, 8'hF1});
    @(negedge clk);
    chk("mr_second_grant", 32'(bus.grant), 32'b010);
    cyc();
    clear_all();

`ifdef UART_TX_ARB_WATCHDOG_EN
    // Owner stalls after one byte: abort after 16 stall cycles
    do_reset();
    bus.tx_ready = 1'b1;
    set_req(1, 1'b1, 8'h31, 1'b0);
    @(negedge clk);
    chk("wd_arb_busy", 32'(bus.busy), 0);
    cyc();
    exp_q.push_back({3'b010, 8'h31});
    @(negedge clk);
    chk("wd_grant", 32'(bus.grant), 32'b010);
    cyc();
    set_req(1, 1'b0, 8'h00, 1'b0);
    set_req(2, 1'b1, 8'h32, 1'b1);
    for (int s = 0; s < 16; s++) begin
      @(negedge clk);
      chk("wd_stall_busy", 32'(bus.busy), 1);
      chk("wd_stall_abort", 32'(bus.abort_pulse), 0);
      cyc();
    end
    @(negedge clk);
    chk("wd_abort", 32'(bus.abort_pulse), 1);
    chk("wd_abort_busy", 32'(bus.busy), 0);
    cyc();
    exp_q.push_back({3'b100, 8'h32});
    @(negedge clk);
    chk("wd_abort_clear", 32'(bus.abort_pulse), 0);
    chk("wd_next_grant", 32'(bus.grant), 32'b100);
    cyc();
    clear_all();

    // Slow serializer only: no abort
    set_req(0, 1'b1, 8'h40, 1'b1);
    bus.tx_ready = 1'b0;
    cyc();
    for (int s = 0; s < 100; s++) begin
      @(negedge clk);
      chk("wd_bp_abort", 32'(bus.abort_pulse), 0);
      chk("wd_bp_busy", 32'(bus.busy), 1);
      cyc();
    end
    bus.tx_ready = 1'b1;
    exp_q.push_back({3'b001, 8'h40});
    @(negedge clk);
    chk("wd_bp_grant", 32'(bus.grant), 32'b001);
    cyc();
    clear_all();
    @(negedge clk);
    chk("wd_bp_done", 32'(bus.busy), 0);
    cyc();
`endif

    // Every expected byte must have been accepted
    chk("queue_empty", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
